// File: rtl/fenotipo_pkg.sv
// Shared constants, FSM state type and size helpers for the serial phenotype loader.
package fenotipo_pkg;

    localparam int DEF_N_LES    = 27;
    localparam int DEF_LE_BITS  = 15;
    localparam int DEF_N_OUTS   = 8;
    localparam int DEF_OUT_BITS = 6;
    localparam int DEF_WORD     = 8;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } fen_state_t;

    function automatic int chrom_bits(input int n_les, input int le_bits,
                                      input int n_outs, input int out_bits);
        return n_les * le_bits + n_outs * out_bits;
    endfunction

    function automatic int n_words(input int bits, input int word);
        return (bits + word - 1) / word;
    endfunction

endpackage

// File: rtl/fenotipo_slicer.sv
// Combinational mapping of the active chromosome onto LE and output-selector descriptors.
module fenotipo_slicer #(
    parameter int N_LES    = 27,
    parameter int LE_BITS  = 15,
    parameter int N_OUTS   = 8,
    parameter int OUT_BITS = 6
) (
    input  logic [N_LES*LE_BITS+N_OUTS*OUT_BITS-1:0] active,
    output logic [N_LES*LE_BITS-1:0]                 conf_les,
    output logic [N_OUTS*OUT_BITS-1:0]               conf_outs
);

    for (genvar i = 0; i < N_LES; i++) begin : g_le
        assign conf_les[i*LE_BITS +: LE_BITS] = active[i*LE_BITS +: LE_BITS];
    end

    // Output selectors sit directly above the LE block.
    for (genvar j = 0; j < N_OUTS; j++) begin : g_out
        assign conf_outs[j*OUT_BITS +: OUT_BITS] = active[N_LES*LE_BITS + j*OUT_BITS +: OUT_BITS];
    end

endmodule

// File: rtl/fenotipo_serial_loader.sv
// Serial chromosome loader: beats fill a shadow register, commit copies it atomically to active.
module fenotipo_serial_loader
    import fenotipo_pkg::*;
#(
    parameter int N_LES    = DEF_N_LES,
    parameter int LE_BITS  = DEF_LE_BITS,
    parameter int N_OUTS   = DEF_N_OUTS,
    parameter int OUT_BITS = DEF_OUT_BITS,
    parameter int WORD     = DEF_WORD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [WORD-1:0]            load_data,
    output logic                       load_ready,
    output logic                       load_done,
    input  logic                       commit,
    output logic                       commit_err,
    output logic                       cfg_update,
    output logic                       cfg_valid,
    output logic [CNT_W-1:0]           gen_count,
    output logic [N_LES*LE_BITS-1:0]   conf_les,
    output logic [N_OUTS*OUT_BITS-1:0] conf_outs,
    output fen_state_t                 state
);

    localparam int CB = chrom_bits(N_LES, LE_BITS, N_OUTS, OUT_BITS);
    localparam int NW = n_words(CB, WORD);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST = IW'(NW - 1);

    // Handshake: a beat transfers on a rising edge where load_valid && load_ready;
    // load_start in the same cycle restarts the load and drops that beat.
    fen_state_t    state_next;
    logic [IW-1:0] cnt;
    logic [CB-1:0] shadow;
    logic [CB-1:0] active;
    logic          beat;
    logic          do_commit;

    assign beat      = load_valid && load_ready && !load_start;
    assign do_commit = commit && (state == FULL) && !load_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (load_start) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (beat && cnt == LAST) state_next = FULL;
                FULL:    if (commit) state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        load_ready = (state == LOAD);
        load_done  = (state == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            shadow     <= '0;
            active     <= '0;
            commit_err <= 1'b0;
            cfg_update <= 1'b0;
            cfg_valid  <= 1'b0;
            gen_count  <= '0;
        end else begin
            commit_err <= commit && !do_commit;
            cfg_update <= do_commit;
            if (load_start) begin
                cnt <= '0;
            end else if (beat) begin
                cnt <= cnt + IW'(1);
                // Bits of the last beat beyond the chromosome have no shadow slot.
                for (int b = 0; b < CB; b++) begin
                    if (cnt == IW'(b / WORD)) shadow[b] <= load_data[b % WORD];
                end
            end
            if (do_commit) begin
                active    <= shadow;
                gen_count <= gen_count + CNT_W'(1);
                cfg_valid <= 1'b1;
            end
        end
    end

    fenotipo_slicer #(
        .N_LES    (N_LES),
        .LE_BITS  (LE_BITS),
        .N_OUTS   (N_OUTS),
        .OUT_BITS (OUT_BITS)
    ) u_slicer (
        .active    (active),
        .conf_les  (conf_les),
        .conf_outs (conf_outs)
    );

endmodule
